baud_tick_generator: RTL and testbench

//  Programmable baud tick source for the UART TX/RX datapath. Divides clk into an

---
 rtl/baud_tick_generator.sv | 139 +++++++++++++
 tb/tb_baud_tick_generator.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/baud_tick_generator.sv
// Programmable UART baud tick source: os_tick every div clocks, with mid/bit ticks at OVERSAMPLE os_ticks per bit.
// Optional fractional divisor accumulator is built when BAUD_FRAC_EN is defined.
module baud_tick_generator #(
   parameter int unsigned DIV_W       = 16,
   parameter int unsigned OVERSAMPLE  = 16,
   parameter int unsigned DEFAULT_DIV = 8,
   parameter int unsigned FRAC_W      = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en_i,
   input  logic [DIV_W-1:0]  div_in_i,
   input  logic [FRAC_W-1:0] frac_in_i,
   input  logic              div_load_i,
   input  logic              restart_i,
   output logic              os_tick_o,
   output logic              mid_tick_o,
   output logic              bit_tick_o,
   output logic [DIV_W-1:0]  div_cur_o,
   output logic              div_err_o
);

   localparam int unsigned     OS_W    = $clog2(OVERSAMPLE);
   localparam logic [OS_W-1:0] MID_IDX = OS_W'(OVERSAMPLE / 2 - 1);
   localparam logic [OS_W-1:0] BIT_IDX = OS_W'(OVERSAMPLE - 1);

   logic [DIV_W-1:0] clk_cnt_q, clk_cnt_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [OS_W-1:0]  os_cnt_q, os_cnt_d;
   logic             os_tick_q, os_tick_d;
   logic             mid_tick_q, mid_tick_d;
   logic             bit_tick_q, bit_tick_d;
   logic             div_err_q, div_err_d;
   logic             load_ok;
   logic             terminal;
   logic [DIV_W:0]   period_m1;

`ifdef BAUD_FRAC_EN
   logic [FRAC_W-1:0] frac_q, frac_d;
   logic [FRAC_W-1:0] acc_q, acc_d;
   // Carry out of the accumulator lengthens the os period that follows it by one clock.
   logic              stretch_q, stretch_d;

   assign period_m1 = {1'b0, div_q} - (DIV_W+1)'(1) + {{DIV_W{1'b0}}, stretch_q};
`else
   logic unused_frac;

   assign unused_frac = ^frac_in_i;
   assign period_m1   = {1'b0, div_q} - (DIV_W+1)'(1);
`endif

   assign load_ok  = div_load_i && (div_in_i != '0);
   assign terminal = en_i && ({1'b0, clk_cnt_q} == period_m1);

   always_comb begin
      // NOTE: every variable gets a default first so no path through this block infers a latch.
      clk_cnt_d  = clk_cnt_q;
      os_cnt_d   = os_cnt_q;
      div_d      = div_q;
      os_tick_d  = 1'b0;
      mid_tick_d = 1'b0;
      bit_tick_d = 1'b0;
      div_err_d  = 1'b0;
`ifdef BAUD_FRAC_EN
      frac_d     = frac_q;
      acc_d      = acc_q;
      stretch_d  = stretch_q;
`endif
      if (load_ok) begin
         div_d     = div_in_i;
         clk_cnt_d = '0;
         os_cnt_d  = '0;
`ifdef BAUD_FRAC_EN
         frac_d    = frac_in_i;
         acc_d     = '0;
         stretch_d = 1'b0;
`endif
      end else begin
         div_err_d = div_load_i;
         if (restart_i) begin
            clk_cnt_d = '0;
            os_cnt_d  = '0;
`ifdef BAUD_FRAC_EN
            acc_d     = '0;
            stretch_d = 1'b0;
`endif
         end else if (terminal) begin
            clk_cnt_d  = '0;
            os_cnt_d   = os_cnt_q + OS_W'(1);
            os_tick_d  = 1'b1;
            mid_tick_d = (os_cnt_q == MID_IDX);
            bit_tick_d = (os_cnt_q == BIT_IDX);
`ifdef BAUD_FRAC_EN
            {stretch_d, acc_d} = {1'b0, acc_q} + {1'b0, frac_q};
`endif
         end else if (en_i) begin
            clk_cnt_d = clk_cnt_q + DIV_W'(1);
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_cnt_q  <= '0;
         os_cnt_q   <= '0;
         div_q      <= DIV_W'(DEFAULT_DIV);
         os_tick_q  <= 1'b0;
         mid_tick_q <= 1'b0;
         bit_tick_q <= 1'b0;
         div_err_q  <= 1'b0;
`ifdef BAUD_FRAC_EN
         frac_q     <= '0;
         acc_q      <= '0;
         stretch_q  <= 1'b0;
`endif
      end else begin
         clk_cnt_q  <= clk_cnt_d;
         os_cnt_q   <= os_cnt_d;
         div_q      <= div_d;
         os_tick_q  <= os_tick_d;
         mid_tick_q <= mid_tick_d;
         bit_tick_q <= bit_tick_d;
         div_err_q  <= div_err_d;
`ifdef BAUD_FRAC_EN
         frac_q     <= frac_d;
         acc_q      <= acc_d;
         stretch_q  <= stretch_d;
`endif
      end
   end

   assign os_tick_o  = os_tick_q;
   assign mid_tick_o = mid_tick_q;
   assign bit_tick_o = bit_tick_q;
   assign div_cur_o  = div_q;
   assign div_err_o  = div_err_q;

endmodule

// File: tb/tb_baud_tick_generator.sv
// Self-checking bench for baud_tick_generator against an arithmetic tick-schedule model.
// Define BAUD_FRAC_EN for both files to exercise the fractional divisor.
module tb_baud_tick_generator;

   localparam int DIV_W   = 16;
   localparam int OS      = 16;
   localparam int DEF_DIV = 8;
   localparam int FRAC_W  = 4;
`ifdef BAUD_FRAC_EN
   localparam bit FRAC_EN = 1'b1;
`else
   localparam bit FRAC_EN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              en = 1'b0;
   logic [DIV_W-1:0]  div_in = '0;
   logic [FRAC_W-1:0] frac_in = '0;
   logic              div_load = 1'b0;
   logic              restart = 1'b0;
   logic              os_tick, mid_tick, bit_tick, div_err;
   logic [DIV_W-1:0]  div_cur;

   int checks = 0;
   int errors = 0;

   baud_tick_generator #(
      .DIV_W(DIV_W), .OVERSAMPLE(OS), .DEFAULT_DIV(DEF_DIV), .FRAC_W(FRAC_W)
   ) dut (
      .clk(clk), .rst(rst), .en_i(en), .div_in_i(div_in), .frac_in_i(frac_in),
      .div_load_i(div_load), .restart_i(restart), .os_tick_o(os_tick),
      .mid_tick_o(mid_tick), .bit_tick_o(bit_tick), .div_cur_o(div_cur),
      .div_err_o(div_err)
   );

   always #5 clk = ~clk;

   // Model: phase is (clocks elapsed in current os interval, number of os intervals completed).
   logic [DIV_W-1:0] m_div = DIV_W'(DEF_DIV);
   int m_frac = 0;
   int m_elapsed = 0;
   int m_k = 0;
   bit exp_os, exp_mid, exp_bit, exp_err;
   logic [3:0] got_v, exp_v;

   assign got_v = {os_tick, mid_tick, bit_tick, div_err};
   assign exp_v = {exp_os, exp_mid, exp_bit, exp_err};

   // Extra clock in interval j: rise in floor(j*frac/2^F) since the previous interval.
   function automatic int extra(int j);
      if (j == 0) return 0;
      return (j * m_frac) / (1 << FRAC_W) - ((j - 1) * m_frac) / (1 << FRAC_W);
   endfunction

   task automatic model_reset();
      m_div = DIV_W'(DEF_DIV);
      m_frac = 0;
      m_elapsed = 0;
      m_k = 0;
      {exp_os, exp_mid, exp_bit, exp_err} = '0;
   endtask

   task automatic model_edge();
      {exp_os, exp_mid, exp_bit, exp_err} = '0;
      if (rst) begin
         model_reset();
      end else if (div_load && div_in != 0) begin
         m_div = div_in;
         m_frac = FRAC_EN ? int'(frac_in) : 0;
         m_elapsed = 0;
         m_k = 0;
      end else begin
         exp_err = div_load;
         if (restart) begin
            m_elapsed = 0;
            m_k = 0;
         end else if (en) begin
            m_elapsed++;
            if (m_elapsed == int'(m_div) + extra(m_k)) begin
               exp_os = 1'b1;
               exp_mid = (m_k % OS) == OS / 2 - 1;
               exp_bit = (m_k % OS) == OS - 1;
               m_k++;
               m_elapsed = 0;
            end
         end
      end
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      checks++;
      if (got_v !== 4'b0000) begin
         errors++;
         $display("FAIL reset_ticks: got %b, expected 0000", got_v);
      end
      checks++;
      if (div_cur !== DIV_W'(DEF_DIV)) begin
         errors++;
         $display("FAIL reset_div_cur: got %0d, expected %0d", div_cur, DEF_DIV);
      end
      rst = 1'b0;
   endtask

   task automatic test_defaults();
      int first_os = -1, first_mid = -1, first_bit = -1;
      en = 1'b1;
      for (int i = 1; i <= 130; i++) begin
         step();
         checks++;
         if (got_v !== exp_v || div_cur !== m_div) begin
            errors++;
            $display("FAIL defaults_cycle%0d: got %b div %0d, expected %b div %0d", i, got_v, div_cur, exp_v, m_div);
         end
         if (os_tick && first_os < 0) first_os = i;
         if (mid_tick && first_mid < 0) first_mid = i;
         if (bit_tick && first_bit < 0) first_bit = i;
      end
      checks++;
      if (first_os != 8 || first_mid != 64 || first_bit != 128) begin
         errors++;
         $display("FAIL defaults_first_ticks: got os %0d mid %0d bit %0d, expected 8 64 128", first_os, first_mid, first_bit);
      end
   endtask

   task automatic test_div_load();
      int first_os = -1, first_bit = -1;
      div_in = DIV_W'(3);
      div_load = 1'b1;
      step();
      div_load = 1'b0;
      checks++;
      if (div_cur !== DIV_W'(3) || got_v !== 4'b0000) begin
         errors++;
         $display("FAIL div_load_cycle: got div %0d ticks %b, expected div 3 ticks 0000", div_cur, got_v);
      end
      for (int i = 1; i <= 50; i++) begin
         step();
         checks++;
         if (got_v !== exp_v || div_cur !== m_div) begin
            errors++;
            $display("FAIL div_load_cycle%0d: got %b div %0d, expected %b div %0d", i, got_v, div_cur, exp_v, m_div);
         end
         if (os_tick && first_os < 0) first_os = i;
         if (bit_tick && first_bit < 0) first_bit = i;
      end
      checks++;
      if (first_os != 3 || first_bit != 48) begin
         errors++;
         $display("FAIL div_load_timing: got os %0d bit %0d, expected 3 48", first_os, first_bit);
      end
   endtask

   task automatic test_div_zero();
      div_in = DIV_W'(DEF_DIV);
      div_load = 1'b1;
      step();
      repeat (13) step();
      div_in = '0;
      div_load = 1'b1;
      step();
      div_load = 1'b0;
      checks++;
      if (div_err !== 1'b1 || div_cur !== DIV_W'(DEF_DIV)) begin
         errors++;
         $display("FAIL div_zero_err: got err %b div %0d, expected err 1 div %0d", div_err, div_cur, DEF_DIV);
      end
      for (int i = 1; i <= 40; i++) begin
         step();
         checks++;
         if (got_v !== exp_v || div_cur !== m_div) begin
            errors++;
            $display("FAIL div_zero_cycle%0d: got %b div %0d, expected %b div %0d", i, got_v, div_cur, exp_v, m_div);
         end
      end
   endtask

   task automatic test_en_hold();
      restart = 1'b1;
      step();
      restart = 1'b0;
      repeat (5) step();
      en = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         step();
         checks++;
         if (got_v !== 4'b0000) begin
            errors++;
            $display("FAIL en_hold_cycle%0d: got %b, expected 0000", i, got_v);
         end
      end
      en = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         step();
         checks++;
         if (os_tick !== (i == 3) || got_v !== exp_v) begin
            errors++;
            $display("FAIL en_resume_edge%0d: got %b, expected os %0d model %b", i, got_v, (i == 3), exp_v);
         end
      end
   endtask

   task automatic test_restart();
      int first_mid = -1, first_bit = -1;
      restart = 1'b1;
      step();
      restart = 1'b0;
      repeat (83) step();
      checks++;
      if (m_k != 10) begin
         errors++;
         $display("FAIL restart_setup: got os count %0d, expected 10", m_k);
      end
      restart = 1'b1;
      step();
      restart = 1'b0;
      for (int i = 1; i <= 130; i++) begin
         step();
         checks++;
         if (got_v !== exp_v) begin
            errors++;
            $display("FAIL restart_cycle%0d: got %b, expected %b", i, got_v, exp_v);
         end
         if (mid_tick && first_mid < 0) first_mid = i;
         if (bit_tick && first_bit < 0) first_bit = i;
      end
      checks++;
      if (first_mid != 64 || first_bit != 128) begin
         errors++;
         $display("FAIL restart_timing: got mid %0d bit %0d, expected 64 128", first_mid, first_bit);
      end
   endtask

   task automatic test_frac();
      int b1 = -1, b2 = -1;
      int want = FRAC_EN ? 136 : 128;
      div_in = DIV_W'(8);
      frac_in = FRAC_W'(8);
      div_load = 1'b1;
      step();
      div_load = 1'b0;
      for (int i = 1; i <= 300; i++) begin
         step();
         checks++;
         if (got_v !== exp_v) begin
            errors++;
            $display("FAIL frac_cycle%0d: got %b, expected %b", i, got_v, exp_v);
         end
         if (bit_tick) begin
            if (b1 < 0) b1 = i;
            else if (b2 < 0) b2 = i;
         end
      end
      checks++;
      if (b1 < 0 || b2 < 0 || b2 - b1 != want) begin
         errors++;
         $display("FAIL frac_bit_period: got %0d (ticks at %0d,%0d), expected %0d", b2 - b1, b1, b2, want);
      end
   endtask

   task automatic test_random();
      for (int i = 1; i <= 3000; i++) begin
         en = ($urandom_range(0, 9) != 0);
         div_load = ($urandom_range(0, 39) == 0);
         div_in = DIV_W'($urandom_range(0, 12));
         frac_in = FRAC_W'($urandom);
         restart = ($urandom_range(0, 49) == 0);
         step();
         checks++;
         if (got_v !== exp_v || div_cur !== m_div) begin
            errors++;
            $display("FAIL random_cycle%0d: got %b div %0d, expected %b div %0d", i, got_v, div_cur, exp_v, m_div);
         end
      end
      {div_load, restart} = 2'b00;
      en = 1'b1;
   endtask

   task automatic test_async_reset();
      div_in = DIV_W'(1);
      div_load = 1'b1;
      step();
      div_load = 1'b0;
      repeat (3) step();
      checks++;
      if (os_tick !== 1'b1 || div_cur !== DIV_W'(1)) begin
         errors++;
         $display("FAIL div1_continuous: got os %b div %0d, expected os 1 div 1", os_tick, div_cur);
      end
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      checks++;
      if (got_v !== 4'b0000 || div_cur !== DIV_W'(DEF_DIV)) begin
         errors++;
         $display("FAIL async_reset: got %b div %0d, expected 0000 div %0d", got_v, div_cur, DEF_DIV);
      end
      step();
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_defaults();
      test_div_load();
      test_div_zero();
      test_en_hold();
      test_restart();
      test_frac();
      test_random();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
